// File: rtl/test_value_uart_tx_pkg.sv
// Shared definitions for the test_value UART reporter: FSM encodings, ASCII constants
// and the hex/character helpers used to build the "HHHH\r\n" line.
package test_value_uart_tx_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MSG_CHARS  = 6;
  localparam int unsigned CHAR_IDX_W = 3;
  localparam int unsigned BIT_IDX_W  = 3;

  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  // Serializer bit-level states; PARITY is only reachable in parity builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Message-level sequencing in the top.
  typedef enum logic {
    MSG_IDLE = 1'b0,
    MSG_SEND = 1'b1
  } msg_state_e;

  function automatic logic [BYTE_W-1:0] hex_ascii(input logic [NIBBLE_W-1:0] n);
    logic [BYTE_W-1:0] c;
    if (n < 4'd10) c = 8'h30 + {4'h0, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Character idx (0..5) of the line for value v.
  function automatic logic [BYTE_W-1:0] msg_char(input logic [DATA_W-1:0]     v,
                                                 input logic [CHAR_IDX_W-1:0] idx);
    logic [BYTE_W-1:0] c;
    case (idx)
      3'd0:    c = hex_ascii(v[15:12]);
      3'd1:    c = hex_ascii(v[11:8]);
      3'd2:    c = hex_ascii(v[7:4]);
      3'd3:    c = hex_ascii(v[3:0]);
      3'd4:    c = ASCII_CR;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Parity bit is present only when TV_UART_PARITY_EN is defined.
module uart_tx_byte
  import test_value_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              tx,
  output logic              busy
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e              state, state_n;
  logic [BAUD_W-1:0]      baud_cnt, baud_n;
  logic [BIT_IDX_W-1:0]   bit_cnt, bit_n;
  logic [BYTE_W-1:0]      shift_q, shift_n;
  logic                   tx_n, busy_n, ready_n;
  logic                   accept_c, baud_last_c;
`ifdef TV_UART_PARITY_EN
  logic                   par_q, par_n;
`endif

  assign accept_c    = byte_valid && byte_ready;
  assign baud_last_c = (baud_cnt == BAUD_LAST);

  // State and datapath registers; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byte_ready <= 1'b1;
`ifdef TV_UART_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_n;
      bit_cnt    <= bit_n;
      shift_q    <= shift_n;
      tx         <= tx_n;
      busy       <= busy_n;
      byte_ready <= ready_n;
`ifdef TV_UART_PARITY_EN
      par_q      <= par_n;
`endif
    end
  end

  // Next state; outputs are precomputed here so tx/busy/byte_ready come from flops.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    tx_n    = tx;
`ifdef TV_UART_PARITY_EN
    par_n   = par_q;
`endif

    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
      end
      ST_START: begin
        if (baud_last_c) begin
          state_n = ST_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift_q[0];
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last_c) begin
          baud_n = '0;
          if (bit_cnt == BIT_IDX_W'(BYTE_W - 1)) begin
`ifdef TV_UART_PARITY_EN
            state_n = ST_PARITY;
            tx_n    = par_q;
`else
            state_n = ST_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + BIT_IDX_W'(1);
            shift_n = {1'b0, shift_q[BYTE_W-1:1]};
            tx_n    = shift_q[1];
          end
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
`ifdef TV_UART_PARITY_EN
      ST_PARITY: begin
        if (baud_last_c) begin
          state_n = ST_STOP;
          baud_n  = '0;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_last_c) begin
          state_n = ST_IDLE;
          baud_n  = '0;
          tx_n    = 1'b1;
        end else begin
          baud_n = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase

    // A byte is only accepted in IDLE or on the last stop-bit cycle, so chars run back to back.
    if (accept_c) begin
      state_n = ST_START;
      baud_n  = '0;
      bit_n   = '0;
      shift_n = byte_in;
      tx_n    = 1'b0;
`ifdef TV_UART_PARITY_EN
      par_n   = ^byte_in;
`endif
    end

    busy_n  = (state_n != ST_IDLE);
    ready_n = (state_n == ST_IDLE) || ((state_n == ST_STOP) && (baud_n == BAUD_LAST));
  end

endmodule

// File: rtl/test_value_uart_tx.sv
// Sends MIPS_TOP test_value over UART as "HHHH\r\n" whenever it changes; only the newest
// unsent value is kept. Define TV_UART_PARITY_EN for 8E1 framing (8N1 otherwise).
module test_value_uart_tx
  import test_value_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] test_value,
  input  logic              tx_en,
  output logic              tx,
  output logic              busy
);

  msg_state_e              msg_state, msg_state_n;
  logic [DATA_W-1:0]       prev_value;
  logic [DATA_W-1:0]       pend_val, pend_val_n;
  logic                    pending, pending_n;
  logic [DATA_W-1:0]       msg_val, msg_val_n;
  logic [CHAR_IDX_W-1:0]   char_idx, char_idx_n;

  logic                    change_c, start_c, byte_valid_c, byte_ready;
  logic [DATA_W-1:0]       newest_c;
  logic [BYTE_W-1:0]       byte_in_c;

  assign change_c = (test_value != prev_value);
  assign newest_c = change_c ? test_value : pend_val;
  assign start_c  = (msg_state == MSG_IDLE) && tx_en && (pending || change_c);

  // Char 0 is offered in the start cycle itself so the start bit begins on that edge.
  assign byte_valid_c = start_c ||
                        ((msg_state == MSG_SEND) && (char_idx != CHAR_IDX_W'(MSG_CHARS)));
  assign byte_in_c    = start_c ? hex_ascii(newest_c[15:12]) : msg_char(msg_val, char_idx);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      msg_state  <= MSG_IDLE;
      prev_value <= '0;
      pend_val   <= '0;
      pending    <= 1'b0;
      msg_val    <= '0;
      char_idx   <= '0;
    end else begin
      msg_state  <= msg_state_n;
      prev_value <= test_value;
      pend_val   <= pend_val_n;
      pending    <= pending_n;
      msg_val    <= msg_val_n;
      char_idx   <= char_idx_n;
    end
  end

  // Message sequencing: latch newest value on start, feed chars 1..5 as the serializer frees up.
  always_comb begin
    msg_state_n = msg_state;
    pend_val_n  = change_c ? test_value : pend_val;
    pending_n   = pending || change_c;
    msg_val_n   = msg_val;
    char_idx_n  = char_idx;

    case (msg_state)
      MSG_IDLE: begin
        if (start_c) begin
          msg_state_n = MSG_SEND;
          msg_val_n   = newest_c;
          char_idx_n  = CHAR_IDX_W'(1);
          pending_n   = 1'b0;
        end
      end
      MSG_SEND: begin
        if (byte_ready) begin
          if (char_idx == CHAR_IDX_W'(MSG_CHARS)) begin
            msg_state_n = MSG_IDLE;
            char_idx_n  = '0;
          end else begin
            char_idx_n = char_idx + CHAR_IDX_W'(1);
          end
        end
      end
      default: begin
        msg_state_n = MSG_IDLE;
        char_idx_n  = '0;
      end
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk        (CLK),
    .rst_n      (RST),
    .byte_in    (byte_in_c),
    .byte_valid (byte_valid_c),
    .byte_ready (byte_ready),
    .tx         (tx),
    .busy       (busy)
  );

endmodule
